// File: rtl/fp16_div_seq.sv
// fp16 divider, a / b, restoring mantissa loop producing one quotient bit per clock.
// Latency: done pulses in the cycle after edge 15 (start sampled at edge 0); specials after edge 2 when EARLY_OUT=1.
// Backpressure: start is honoured only in IDLE; busy stalls the requester, with no queueing of extra starts.
module fp16_div_seq #(
  parameter bit EARLY_OUT = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic        div_by_zero,
  output logic        overflow
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_UNPACK = 3'd1,
    S_DIV    = 3'd2,
    S_NORM   = 3'd3,
    S_FIN    = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_next;

  // Operands are captured once and stay stable for the whole operation.
  logic [15:0] r_a;
  logic [15:0] r_b;

  // Divide datapath.
  logic [11:0] r_rem;
  logic [10:0] r_mb;
  logic [11:0] r_q;
  logic [3:0]  r_cnt;
  logic [6:0]  r_exp;
  logic [9:0]  r_mant;

  // Registered outputs.
  logic        r_busy;
  logic        r_done;
  logic [15:0] r_result;
  logic        r_dbz;
  logic        r_ovf;

  // Operand classification; subnormals count as zero.
  logic [4:0]  w_ea;
  logic [4:0]  w_eb;
  logic        w_sign;
  logic        w_a_zero;
  logic        w_b_zero;
  logic        w_a_inf;
  logic        w_b_inf;
  logic        w_a_nan;
  logic        w_b_nan;
  logic        w_special;
  logic [15:0] w_spec_res;
  logic        w_spec_dbz;

  logic [10:0] w_ma;
  logic [10:0] w_mbx;
  logic [6:0]  w_exp_diff;
  logic        w_ge;
  logic [11:0] w_rem_sub;
  logic [11:0] w_rem_nxt;

  logic [15:0] w_fin_res;
  logic        w_fin_dbz;
  logic        w_fin_ovf;

  assign w_ea     = r_a[14:10];
  assign w_eb     = r_b[14:10];
  assign w_sign   = r_a[15] ^ r_b[15];
  assign w_a_zero = (w_ea == 5'd0);
  assign w_b_zero = (w_eb == 5'd0);
  assign w_a_inf  = (w_ea == 5'h1f) && (r_a[9:0] == 10'd0);
  assign w_b_inf  = (w_eb == 5'h1f) && (r_b[9:0] == 10'd0);
  assign w_a_nan  = (w_ea == 5'h1f) && (r_a[9:0] != 10'd0);
  assign w_b_nan  = (w_eb == 5'h1f) && (r_b[9:0] != 10'd0);

  assign w_ma       = w_a_zero ? 11'd0 : {1'b1, r_a[9:0]};
  assign w_mbx      = w_b_zero ? 11'd0 : {1'b1, r_b[9:0]};
  assign w_exp_diff = {2'b00, w_ea} - {2'b00, w_eb} + 7'd15;

  assign w_ge      = (r_rem >= {1'b0, r_mb});
  assign w_rem_sub = r_rem - {1'b0, r_mb};
  assign w_rem_nxt = w_ge ? w_rem_sub : r_rem;

  assign busy        = r_busy;
  assign done        = r_done;
  assign result      = r_result;
  assign div_by_zero = r_dbz;
  assign overflow    = r_ovf;

  // Special-operand result, in priority order: NaN, 0/0 or inf/inf, x/0, inf/x, x/inf or 0/x.
  always_comb begin
    w_special  = 1'b1;
    w_spec_res = 16'h7E00;
    w_spec_dbz = 1'b0;
    if (w_a_nan || w_b_nan) begin
      w_spec_res = 16'h7E00;
    end else if ((w_a_zero && w_b_zero) || (w_a_inf && w_b_inf)) begin
      w_spec_res = 16'h7E00;
    end else if (w_b_zero && !w_a_inf) begin
      w_spec_res = {w_sign, 5'h1f, 10'd0};
      w_spec_dbz = 1'b1;
    end else if (w_a_inf) begin
      w_spec_res = {w_sign, 5'h1f, 10'd0};
    end else if (w_b_inf || w_a_zero) begin
      w_spec_res = {w_sign, 15'd0};
    end else begin
      w_special = 1'b0;
    end
  end

  // Final packing of the normalised quotient with exponent saturation/flush.
  always_comb begin
    w_fin_res = {w_sign, r_exp[4:0], r_mant};
    w_fin_dbz = 1'b0;
    w_fin_ovf = 1'b0;
    if (w_special) begin
      w_fin_res = w_spec_res;
      w_fin_dbz = w_spec_dbz;
    end else if ($signed(r_exp) >= 7'sd31) begin
      w_fin_res = {w_sign, 5'h1f, 10'd0};
      w_fin_ovf = 1'b1;
    end else if ($signed(r_exp) <= 7'sd0) begin
      w_fin_res = {w_sign, 15'd0};
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (start) w_next = S_UNPACK;
      S_UNPACK: w_next = (EARLY_OUT && w_special) ? S_FIN : S_DIV;
      S_DIV:    if (r_cnt == 4'd11) w_next = S_NORM;
      S_NORM:   w_next = S_FIN;
      S_FIN:    w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Datapath: capture on accept, unpack, shift-subtract loop, normalise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a    <= 16'd0;
      r_b    <= 16'd0;
      r_rem  <= 12'd0;
      r_mb   <= 11'd0;
      r_q    <= 12'd0;
      r_cnt  <= 4'd0;
      r_exp  <= 7'd0;
      r_mant <= 10'd0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a <= a;
            r_b <= b;
          end
        end
        S_UNPACK: begin
          r_rem <= {1'b0, w_ma};
          r_mb  <= w_mbx;
          r_q   <= 12'd0;
          r_cnt <= 4'd0;
          r_exp <= w_exp_diff;
        end
        S_DIV: begin
          r_rem <= w_rem_nxt << 1;
          r_q   <= {r_q[10:0], w_ge};
          r_cnt <= r_cnt + 4'd1;
        end
        S_NORM: begin
          // Ratio below 1 leaves bit 11 clear: use one more quotient bit and drop the exponent.
          if (r_q[11]) begin
            r_mant <= r_q[10:1];
          end else begin
            r_mant <= r_q[9:0];
            r_exp  <= r_exp - 7'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Handshake and result registers; flags clear on accept, result held until the next completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= 16'd0;
      r_dbz    <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      if (r_done) r_done <= 1'b0;
      if (r_state == S_IDLE && start) begin
        r_busy <= 1'b1;
        r_dbz  <= 1'b0;
        r_ovf  <= 1'b0;
      end else if (r_state == S_FIN) begin
        r_busy   <= 1'b0;
        r_done   <= 1'b1;
        r_result <= w_fin_res;
        r_dbz    <= w_fin_dbz;
        r_ovf    <= w_fin_ovf;
      end
    end
  end

endmodule

// File: tb/tb_fp16_div_seq.sv
// Bench for fp16_div_seq: vector table, directed handshake/reset sequences, random ops vs reference model.
// Two instances run in lockstep: EARLY_OUT=1 (u_dut) and EARLY_OUT=0 (u_dut0).
// Every wait on the DUT is bounded by a cycle budget.
module tb_fp16_div_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;

  logic        busy1, done1, dbz1, ovf1;
  logic [15:0] res1;
  logic        busy0, done0, dbz0, ovf0;
  logic [15:0] res0;

  int n_checks = 0;
  int n_fail   = 0;

  // Captured per operation by run_op.
  logic [15:0] cap_res1, cap_res0;
  logic        cap_dbz1, cap_ovf1, cap_dbz0, cap_ovf0;
  int          lat1, lat0;
  logic        ovl, busy_e1, done_e1, done_at_start;
  logic [1:0]  flg_e1;

  fp16_div_seq #(.EARLY_OUT(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy1), .done(done1), .result(res1),
    .div_by_zero(dbz1), .overflow(ovf1)
  );

  fp16_div_seq #(.EARLY_OUT(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy0), .done(done0), .result(res0),
    .div_by_zero(dbz0), .overflow(ovf0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] va;
    logic [15:0] vb;
    logic [15:0] er;
    logic        edbz;
    logic        eovf;
    logic        esp;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Reference: real-valued ratio of the significands, truncated, then exponent range handling.
  // Returns {special, overflow, div_by_zero, result}.
  function automatic logic [18:0] ref_div(input logic [15:0] x, input logic [15:0] y);
    int ex, ey, ma, mb, q, e, sig;
    logic s, zx, zy, ix, iy, nx, ny;
    logic [4:0] ev;
    logic [9:0] mv;
    ex = int'(x[14:10]);
    ey = int'(y[14:10]);
    s  = x[15] ^ y[15];
    zx = (ex == 0);
    zy = (ey == 0);
    ix = (ex == 31) && (x[9:0] == 10'd0);
    iy = (ey == 31) && (y[9:0] == 10'd0);
    nx = (ex == 31) && (x[9:0] != 10'd0);
    ny = (ey == 31) && (y[9:0] != 10'd0);
    if (nx || ny) return {3'b100, 16'h7E00};
    if ((zx && zy) || (ix && iy)) return {3'b100, 16'h7E00};
    if (zy) return {3'b101, s, 5'h1f, 10'h000};
    if (ix) return {3'b100, s, 5'h1f, 10'h000};
    if (iy || zx) return {3'b100, s, 15'h0000};
    ma = 1024 + int'(x[9:0]);
    mb = 1024 + int'(y[9:0]);
    q  = (ma * 4096) / mb;          // floor(ratio * 4096), ratio in (0.5, 2)
    if (q >= 4096) begin
      sig = q / 4;
      e   = ex - ey + 15;
    end else begin
      sig = q / 2;
      e   = ex - ey + 14;
    end
    if (e >= 31) return {3'b010, s, 5'h1f, 10'h000};
    if (e <= 0)  return {3'b000, s, 15'h0000};
    ev = e[4:0];
    mv = 10'(sig - 1024);
    return {3'b000, s, ev, mv};
  endfunction

  // Start one operation (start seen at edge 0) and wait for both instances to finish.
  // glitch > 0 pulses start with other operands at that edge.
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb, input int glitch);
    @(negedge clk);
    done_at_start = done1;
    a = ta;
    b = tb;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat1 = -1;
    lat0 = -1;
    ovl  = 1'b0;
    busy_e1 = 1'b0;
    done_e1 = 1'b0;
    flg_e1  = 2'b00;
    for (int e = 1; e <= 40; e++) begin
      if (e == glitch) begin
        a = 16'h3C00;
        b = 16'h0000;
        start = 1'b1;
      end
      @(posedge clk);
      #1;
      if (e == glitch) start = 1'b0;
      if ((busy1 && done1) || (busy0 && done0)) ovl = 1'b1;
      if (e == 1) begin
        busy_e1 = busy1;
        done_e1 = done1;
        flg_e1  = {dbz1, ovf1};
      end
      if (done1 && lat1 < 0) begin
        lat1 = e; cap_res1 = res1; cap_dbz1 = dbz1; cap_ovf1 = ovf1;
      end
      if (done0 && lat0 < 0) begin
        lat0 = e; cap_res0 = res0; cap_dbz0 = dbz0; cap_ovf0 = ovf0;
      end
      if (lat1 >= 0 && lat0 >= 0) break;
    end
  endtask

  task automatic do_op(input logic [15:0] ta, input logic [15:0] tb, input logic [15:0] er,
                       input logic edbz, input logic eovf, input logic esp,
                       input int glitch, input string tag);
    run_op(ta, tb, glitch);
    chk($sformatf("%s res", tag),       32'(cap_res1), 32'(er));
    chk($sformatf("%s dbz", tag),       32'(cap_dbz1), 32'(edbz));
    chk($sformatf("%s ovf", tag),       32'(cap_ovf1), 32'(eovf));
    chk($sformatf("%s lat", tag),       32'(lat1),     esp ? 32'd2 : 32'd15);
    chk($sformatf("%s res eo0", tag),   32'(cap_res0), 32'(er));
    chk($sformatf("%s dbz eo0", tag),   32'(cap_dbz0), 32'(edbz));
    chk($sformatf("%s ovf eo0", tag),   32'(cap_ovf0), 32'(eovf));
    chk($sformatf("%s lat eo0", tag),   32'(lat0),     32'd15);
    chk($sformatf("%s busy e1", tag),   32'(busy_e1),  32'd1);
    chk($sformatf("%s busy&done", tag), 32'(ovl),      32'd0);
  endtask

  initial begin
    logic [18:0] m;
    logic [15:0] ra, rb;
    logic        saw_done;

    vecs[0]  = {16'h4600, 16'h4200, 16'h4000, 1'b0, 1'b0, 1'b0}; //  6 / 3
    vecs[1]  = {16'h3C00, 16'h4200, 16'h3555, 1'b0, 1'b0, 1'b0}; //  1 / 3, shift path
    vecs[2]  = {16'hC600, 16'h4000, 16'hC200, 1'b0, 1'b0, 1'b0}; // -6 / 2
    vecs[3]  = {16'h3C00, 16'h0000, 16'h7C00, 1'b1, 1'b0, 1'b1}; //  1 / 0
    vecs[4]  = {16'h0000, 16'h0000, 16'h7E00, 1'b0, 1'b0, 1'b1}; //  0 / 0
    vecs[5]  = {16'h7BFF, 16'h1400, 16'h7C00, 1'b0, 1'b1, 1'b0}; //  overflow
    vecs[6]  = {16'h0400, 16'h7BFF, 16'h0000, 1'b0, 1'b0, 1'b0}; //  underflow flush
    vecs[7]  = {16'h7E00, 16'h3C00, 16'h7E00, 1'b0, 1'b0, 1'b1}; //  NaN / 1
    vecs[8]  = {16'h7C00, 16'h7C00, 16'h7E00, 1'b0, 1'b0, 1'b1}; //  inf / inf
    vecs[9]  = {16'hFC00, 16'h3C00, 16'hFC00, 1'b0, 1'b0, 1'b1}; // -inf / 1
    vecs[10] = {16'h3C00, 16'hFC00, 16'h8000, 1'b0, 1'b0, 1'b1}; //  1 / -inf
    vecs[11] = {16'h8000, 16'h3C00, 16'h8000, 1'b0, 1'b0, 1'b1}; // -0 / 1
    vecs[12] = {16'h0001, 16'h3C00, 16'h0000, 1'b0, 1'b0, 1'b1}; //  subnormal / 1
    vecs[13] = {16'h7C00, 16'h0000, 16'h7C00, 1'b0, 1'b0, 1'b1}; //  inf / 0
    vecs[14] = {16'hBC00, 16'h8000, 16'h7C00, 1'b1, 1'b0, 1'b1}; // -1 / -0
    vecs[15] = {16'h3C00, 16'h0200, 16'h7C00, 1'b1, 1'b0, 1'b1}; //  1 / subnormal

    rst_n = 1'b0;
    start = 1'b0;
    a = 16'd0;
    b = 16'd0;
    repeat (2) @(negedge clk);
    chk("reset busy",   32'(busy1),  32'd0);
    chk("reset done",   32'(done1),  32'd0);
    chk("reset result", 32'(res1),   32'd0);
    chk("reset dbz",    32'(dbz1),   32'd0);
    chk("reset ovf",    32'(ovf1),   32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle busy", 32'(busy1), 32'd0);

    for (int i = 0; i < 16; i++) begin
      do_op(vecs[i].va, vecs[i].vb, vecs[i].er, vecs[i].edbz, vecs[i].eovf, vecs[i].esp,
            0, $sformatf("vec%0d", i));
    end

    // Flags are held while idle, then cleared when the next start is accepted.
    do_op(16'h3C00, 16'h0000, 16'h7C00, 1'b1, 1'b0, 1'b1, 0, "dbz op");
    repeat (3) @(negedge clk);
    chk("dbz held",    32'(dbz1), 32'd1);
    chk("result held", 32'(res1), 32'h7C00);
    do_op(16'h4600, 16'h4200, 16'h4000, 1'b0, 1'b0, 1'b0, 0, "after dbz");
    chk("flags clear on accept", 32'(flg_e1), 32'd0);

    // A start mid-operation is ignored.
    do_op(16'h4600, 16'h4200, 16'h4000, 1'b0, 1'b0, 1'b0, 5, "glitch start");

    // Start raised during the done cycle is accepted back-to-back.
    do_op(16'h3C00, 16'h4200, 16'h3555, 1'b0, 1'b0, 1'b0, 0, "back2back");
    chk("b2b done at start", 32'(done_at_start), 32'd1);
    chk("b2b done dropped",  32'(done_e1),       32'd0);

    // Reset dropped at edge 8 aborts the operation.
    @(negedge clk);
    a = 16'h4600;
    b = 16'h4200;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (8) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("arst busy",   32'(busy1), 32'd0);
    chk("arst done",   32'(done1), 32'd0);
    chk("arst result", 32'(res1),  32'd0);
    chk("arst busy eo0", 32'(busy0), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (done1 || done0 || busy1 || busy0) saw_done = 1'b1;
    end
    chk("no done after abort", 32'(saw_done), 32'd0);
    do_op(16'h3C00, 16'h4200, 16'h3555, 1'b0, 1'b0, 1'b0, 0, "post reset");

    // Random operands against the reference model.
    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if ($urandom_range(0, 3) != 0) begin
        ra[14:10] = 5'($urandom_range(1, 30));
        rb[14:10] = 5'($urandom_range(1, 30));
      end
      m = ref_div(ra, rb);
      do_op(ra, rb, m[15:0], m[16], m[17], m[18], 0, $sformatf("rand%0d %h/%h", i, ra, rb));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
